// File: rtl/spi_host_ctrl.sv
// spi_host_ctrl: single-lane SPI host, one bit per clk, 11-bit command frames.
// Ports: clk, rst (async high), req_valid/req_ready/req_op/req_data request
//   port, rsp_valid/rsp_data read response strobe, busy, MOSI, SS_n, MISO.
// Optional: define SPI_HOST_TXN_CNT_EN to add the 16-bit txn_cnt output.
module spi_host_ctrl #(
  parameter int RD_WAIT  = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       MOSI,
  output logic       SS_n,
  input  logic       MISO
`ifdef SPI_HOST_TXN_CNT_EN
  ,
  output logic [15:0] txn_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_WAIT,
    S_RECV,
    S_DONE,
    S_GAP
  } state_t;

  localparam logic [3:0] SHIFT_LAST = 4'd10;
  localparam logic [3:0] WAIT_LAST  = 4'(RD_WAIT - 1);
  localparam logic [3:0] RECV_LAST  = 4'd7;
  localparam logic [3:0] GAP_LAST   = 4'(IDLE_GAP - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [10:0] frame;
  logic [10:0] frame_nxt;
  logic [6:0]  shreg;
  logic        accept;
  logic        is_rd;
  logic        ss_n_d;
  logic        mosi_d;
  logic        rsp_valid_d;
  logic [3:0]  bit_idx;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready;
  assign is_rd     = (frame[9:8] == 2'b11);

  // Read-data frames carry no payload, so the data field is forced low.
  always_comb begin
    frame_nxt = frame;
    if (accept) begin
      frame_nxt = {req_op[1], req_op,
                   (req_op == 2'b11) ? 8'h00 : req_data};
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_LEAD;
      S_LEAD:  state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (cnt == SHIFT_LAST) state_nxt = is_rd ? S_WAIT : S_GAP;
      end
      S_WAIT:  if (cnt == WAIT_LAST) state_nxt = S_RECV;
      S_RECV:  if (cnt == RECV_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_GAP;
      S_GAP:   if (cnt == GAP_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Counter restarts at zero on every state entry.
    if (state_nxt != state || state_nxt == S_IDLE) begin
      cnt_nxt = 4'd0;
    end else begin
      cnt_nxt = cnt + 4'd1;
    end
  end

  // Pins are decoded from the next state and registered, so MOSI/SS_n
  // come straight off flops with no path from the request port.
  always_comb begin
    ss_n_d      = 1'b1;
    mosi_d      = 1'b0;
    rsp_valid_d = 1'b0;
    bit_idx     = SHIFT_LAST - cnt_nxt;
    unique case (state_nxt)
      S_LEAD: begin
        ss_n_d = 1'b0;
        mosi_d = frame_nxt[10];
      end
      S_SHIFT: begin
        ss_n_d = 1'b0;
        mosi_d = frame_nxt[bit_idx];
      end
      S_WAIT, S_RECV: ss_n_d = 1'b0;
      S_DONE: rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      frame     <= 11'd0;
      shreg     <= 7'd0;
      rsp_data  <= 8'h00;
      rsp_valid <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      frame     <= frame_nxt;
      rsp_valid <= rsp_valid_d;
      SS_n      <= ss_n_d;
      MOSI      <= mosi_d;
      if (state == S_RECV) begin
        shreg <= {shreg[5:0], MISO};
      end
      // Last MISO bit goes straight into the response byte.
      if (state == S_RECV && state_nxt == S_DONE) begin
        rsp_data <= {shreg, MISO};
      end
    end
  end

`ifdef SPI_HOST_TXN_CNT_EN
  logic frame_end;

  assign frame_end = (state == S_SHIFT && state_nxt == S_GAP) ||
                     (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_cnt <= 16'h0000;
    end else if (frame_end) begin
      txn_cnt <= txn_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_spi_host_ctrl.sv
// tb_spi_host_ctrl: scoreboard bench for spi_host_ctrl with a small
// SPI-slave/RAM model on MOSI/SS_n/MISO.
module tb_spi_host_ctrl;

  localparam int RD_WAIT  = 2;
  localparam int IDLE_GAP = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       MOSI;
  logic       SS_n;
  logic       MISO = 1'b0;
`ifdef SPI_HOST_TXN_CNT_EN
  logic [15:0] txn_cnt;
`endif

  spi_host_ctrl #(
    .RD_WAIT  (RD_WAIT),
    .IDLE_GAP (IDLE_GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .MOSI      (MOSI),
    .SS_n      (SS_n),
    .MISO      (MISO)
`ifdef SPI_HOST_TXN_CNT_EN
    ,
    .txn_cnt   (txn_cnt)
`endif
  );

  always #5 clk = ~clk;

  int chk_n = 0;
  int pass_n = 0;

  int          exp_len_q[$];
  logic [31:0] exp_bits_q[$];
  logic [7:0]  exp_rsp_q[$];
  int          obs_len_q[$];
  logic [31:0] obs_bits_q[$];
  int          obs_gap_q[$];
  logic [7:0]  obs_rsp_q[$];
  int          ovl_err = 0;

  // Frame monitor: records MOSI per SS_n-low window and high-run lengths.
  logic [31:0] cur_bits = '0;
  int          cur_len = 0;
  int          high_run = 0;
  bit          in_frame = 1'b0;

  always @(negedge clk) begin
    if (SS_n === 1'b0) begin
      if (!in_frame) begin
        obs_gap_q.push_back(high_run);
        cur_bits = '0;
        cur_len  = 0;
        in_frame = 1'b1;
      end
      cur_bits = {cur_bits[30:0], MOSI};
      cur_len++;
    end else begin
      if (in_frame) begin
        obs_len_q.push_back(cur_len);
        obs_bits_q.push_back(cur_bits);
        in_frame = 1'b0;
        high_run = 0;
      end
      high_run++;
    end
    if (rsp_valid === 1'b1) obs_rsp_q.push_back(rsp_data);
    if (busy === 1'b1 && req_ready === 1'b1) ovl_err++;
  end

  // Slave/RAM model: decodes the 11-bit command and serves read data.
  int          k = 0;
  logic [10:0] rx = '0;
  logic [7:0]  s_addr = 8'h00;
  logic [7:0]  rd_byte = 8'h00;
  logic [7:0]  mem [256];

  always @(negedge clk) begin
    int j;
    if (SS_n !== 1'b0) begin
      k    = 0;
      MISO = 1'b0;
    end else begin
      if (k >= 1 && k <= 11) rx = {rx[9:0], MOSI};
      if (k == 11) begin
        case (rx[9:8])
          2'b00, 2'b10: s_addr = rx[7:0];
          2'b01:        mem[s_addr] = rx[7:0];
          default:      rd_byte = mem[s_addr];
        endcase
      end
      j = k - (12 + RD_WAIT);
      if (j >= 0 && j < 8) MISO = rd_byte[7 - j];
      else MISO = 1'b0;
      k++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (required finish)");
    $fatal(1);
  end

  task automatic send(input logic [1:0] op, input logic [7:0] d,
                      input bit track);
    logic [10:0] fr;
    int          len;
    bit          ok;
    if (track) begin
      fr  = {op[1], op, (op == 2'b11) ? 8'h00 : d};
      len = (op == 2'b11) ? 20 + RD_WAIT : 12;
      exp_len_q.push_back(len);
      exp_bits_q.push_back(32'({fr[10], fr}) << (len - 12));
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    ok        = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (!ok) begin
      chk_n++;
      $display("FAIL send_timeout op=%0d: req_ready never 1", op);
    end
  endtask

  task automatic check_frames(input int n, input string tag);
    for (int f = 0; f < n; f++) begin
      int t = 0;
      while (obs_len_q.size() == 0 && t < 400) begin
        @(negedge clk);
        #1;
        t++;
      end
      chk_n++;
      if (obs_len_q.size() == 0 || exp_len_q.size() == 0) begin
        $display("FAIL %s_frame%0d: no frame seen, required one", tag, f);
      end else begin
        int          ol;
        int          el;
        logic [31:0] ob;
        logic [31:0] eb;
        ol = obs_len_q.pop_front();
        el = exp_len_q.pop_front();
        ob = obs_bits_q.pop_front();
        eb = exp_bits_q.pop_front();
        if (ol !== el)
          $display("FAIL %s_len%0d: got %0d required %0d", tag, f, ol, el);
        else pass_n++;
        chk_n++;
        if (ob !== eb)
          $display("FAIL %s_mosi%0d: got %h required %h", tag, f, ob, eb);
        else pass_n++;
      end
    end
  endtask

  task automatic check_gap(input int exp_gc, input string tag);
    int gc = 0;
    bit ss_bad = 1'b0;
    while (req_ready !== 1'b1 && gc < 20) begin
      if (SS_n !== 1'b1) ss_bad = 1'b1;
      @(negedge clk);
      #1;
      gc++;
    end
    chk_n++;
    if (gc !== exp_gc || ss_bad)
      $display("FAIL %s_gap: got %0d cycles ss_bad=%0d required %0d,0",
               tag, gc, ss_bad, exp_gc);
    else pass_n++;
  endtask

  task automatic check_rsps(input string tag);
    while (exp_rsp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_rsp_q.pop_front();
      chk_n++;
      if (obs_rsp_q.size() == 0) begin
        $display("FAIL %s_rsp: no rsp_valid, required %h", tag, e);
      end else begin
        logic [7:0] o;
        o = obs_rsp_q.pop_front();
        if (o !== e) $display("FAIL %s_rsp: got %h required %h", tag, o, e);
        else pass_n++;
      end
    end
    chk_n++;
    if (obs_rsp_q.size() != 0)
      $display("FAIL %s_rsp_extra: got %0d extra pulses required 0",
               tag, obs_rsp_q.size());
    else pass_n++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_n++;
    if (SS_n !== 1'b1 || MOSI !== 1'b0)
      $display("FAIL rst_hold: SS_n=%b MOSI=%b required 1,0", SS_n, MOSI);
    else pass_n++;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk_n++;
    if (SS_n !== 1'b1) $display("FAIL rst_ss_n: got %b required 1", SS_n);
    else pass_n++;
    chk_n++;
    if (MOSI !== 1'b0) $display("FAIL rst_mosi: got %b required 0", MOSI);
    else pass_n++;
    chk_n++;
    if (req_ready !== 1'b1)
      $display("FAIL rst_ready: got %b required 1", req_ready);
    else pass_n++;
    chk_n++;
    if (rsp_valid !== 1'b0)
      $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid);
    else pass_n++;
    chk_n++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy);
    else pass_n++;
    chk_n++;
    if (rsp_data !== 8'h00)
      $display("FAIL rst_rsp_data: got %h required 00", rsp_data);
    else pass_n++;
  endtask

  task automatic test_write_addr();
    send(2'b00, 8'h5A, 1'b1);
    check_frames(1, "wr_addr");
    check_gap(IDLE_GAP, "wr_addr");
    check_rsps("wr_addr");
  endtask

  task automatic test_read_data();
    mem[s_addr] = 8'hC3;
    exp_rsp_q.push_back(8'hC3);
    send(2'b11, 8'hFF, 1'b1);
    check_frames(1, "rd_data");
    check_gap(IDLE_GAP + 1, "rd_data");
    check_rsps("rd_data");
    repeat (3) @(negedge clk);
    chk_n++;
    if (rsp_data !== 8'hC3)
      $display("FAIL rd_hold: got %h required c3", rsp_data);
    else pass_n++;
  endtask

  task automatic test_back_to_back();
    obs_gap_q.delete();
    send(2'b00, 8'h10, 1'b1);
    send(2'b01, 8'hA5, 1'b1);
    send(2'b10, 8'h10, 1'b1);
    exp_rsp_q.push_back(8'hA5);
    send(2'b11, 8'h00, 1'b1);
    check_frames(4, "b2b");
    chk_n++;
    if (obs_gap_q.size() != 4)
      $display("FAIL b2b_gapcnt: got %0d required 4", obs_gap_q.size());
    else pass_n++;
    void'(obs_gap_q.pop_front());
    for (int i = 0; i < 3 && obs_gap_q.size() > 0; i++) begin
      int g;
      g = obs_gap_q.pop_front();
      chk_n++;
      if (g !== IDLE_GAP + 1)
        $display("FAIL b2b_gap%0d: got %0d required %0d", i, g, IDLE_GAP + 1);
      else pass_n++;
    end
    check_rsps("b2b");
    chk_n++;
    if (ovl_err !== 0)
      $display("FAIL ready_busy: got %0d overlaps required 0", ovl_err);
    else pass_n++;
  endtask

  task automatic test_reset_mid();
    send(2'b01, 8'hFF, 1'b0);
    repeat (6) @(negedge clk);
    chk_n++;
    if (SS_n !== 1'b0 || MOSI !== 1'b1)
      $display("FAIL mid_pre: SS_n=%b MOSI=%b required 0,1", SS_n, MOSI);
    else pass_n++;
    #2;
    rst = 1'b1;
    #1;
    chk_n++;
    if (SS_n !== 1'b1 || MOSI !== 1'b0)
      $display("FAIL mid_async: SS_n=%b MOSI=%b required 1,0", SS_n, MOSI);
    else pass_n++;
    chk_n++;
    if (busy !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL mid_idle: busy=%b ready=%b required 0,1",
               busy, req_ready);
    else pass_n++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    obs_len_q.delete();
    obs_bits_q.delete();
    obs_rsp_q.delete();
    send(2'b01, 8'h3C, 1'b1);
    check_frames(1, "post_rst");
    check_gap(IDLE_GAP, "post_rst");
  endtask

`ifdef SPI_HOST_TXN_CNT_EN
  task automatic test_txn_cnt();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obs_len_q.delete();
    obs_bits_q.delete();
    obs_rsp_q.delete();
    send(2'b00, 8'h20, 1'b1);
    send(2'b01, 8'h77, 1'b1);
    send(2'b10, 8'h20, 1'b1);
    exp_rsp_q.push_back(8'h77);
    send(2'b11, 8'h00, 1'b1);
    check_frames(4, "txn");
    check_rsps("txn");
    repeat (3) @(negedge clk);
    chk_n++;
    if (txn_cnt !== 16'd4)
      $display("FAIL txn_cnt: got %0d required 4", txn_cnt);
    else pass_n++;
  endtask
`endif

  initial begin
    test_reset();
    test_write_addr();
    test_read_data();
    test_back_to_back();
    test_reset_mid();
`ifdef SPI_HOST_TXN_CNT_EN
    test_txn_cnt();
`endif
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
